// File: rtl/mod_w_sched.sv
// Streaming SHA-2 message-schedule expander: takes one 16-word block and emits
// W[0..ROUNDS-1] one word per cycle, using a 16-entry ring buffer.
module mod_w_sched #(
  parameter  int unsigned WORD_W = 32,
  parameter  int unsigned ROUNDS = 64,
  localparam int unsigned T_W    = $clog2(ROUNDS)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              FLUSH,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [WORD_W-1:0] D_IN,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [WORD_W-1:0] D_OUT,
  output logic [T_W-1:0]    T_OUT,
  output logic              LAST
);

  if (WORD_W != 32 && WORD_W != 64) begin : g_bad_word_w
    $error("mod_w_sched: WORD_W must be 32 or 64");
  end
  if (ROUNDS < 17 || ROUNDS > 128) begin : g_bad_rounds
    $error("mod_w_sched: ROUNDS must be in 17..128");
  end

  typedef enum logic {LOAD, EXPAND} phase_t;

  phase_t            phase, phase_nx;
  logic [T_W-1:0]    t, t_nx;
  logic [WORD_W-1:0] ring [16];
  logic              slot_free, in_fire, exp_fire;
  logic [3:0]        idx;
  logic [WORD_W-1:0] w_new;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
    if (WORD_W == 64) return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
    if (WORD_W == 64) return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Handshake qualification, schedule recurrence and next phase/round.
  always_comb begin
    slot_free = !OUT_VALID || OUT_READY;
    IN_READY  = (phase == LOAD) && slot_free;
    in_fire   = IN_READY && IN_VALID && !FLUSH;
    exp_fire  = (phase == EXPAND) && slot_free && !FLUSH;
    idx       = t[3:0];
    // (t-16)%16 aliases t%16: the oldest word is read before being overwritten.
    w_new     = sig1(ring[4'(idx - 4'd2)]) + ring[4'(idx - 4'd7)]
              + sig0(ring[4'(idx - 4'd15)]) + ring[idx];
    phase_nx  = phase;
    t_nx      = t;
    if (FLUSH) begin
      phase_nx = LOAD;
      t_nx     = '0;
    end else if (in_fire) begin
      t_nx = t + T_W'(1);
      if (t == T_W'(15)) phase_nx = EXPAND;
    end else if (exp_fire) begin
      if (t == T_W'(ROUNDS - 1)) begin
        t_nx     = '0;
        phase_nx = LOAD;
      end else begin
        t_nx = t + T_W'(1);
      end
    end
  end

  // Phase/round state and the output register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      phase     <= LOAD;
      t         <= '0;
      OUT_VALID <= 1'b0;
      D_OUT     <= '0;
      T_OUT     <= '0;
      LAST      <= 1'b0;
    end else begin
      phase <= phase_nx;
      t     <= t_nx;
      if (FLUSH) begin
        OUT_VALID <= 1'b0;
        LAST      <= 1'b0;
      end else if (in_fire) begin
        OUT_VALID <= 1'b1;
        D_OUT     <= D_IN;
        T_OUT     <= t;
        LAST      <= 1'b0;
      end else if (exp_fire) begin
        OUT_VALID <= 1'b1;
        D_OUT     <= w_new;
        T_OUT     <= t;
        LAST      <= (t == T_W'(ROUNDS - 1));
      end else if (OUT_READY) begin
        OUT_VALID <= 1'b0;
        LAST      <= 1'b0;
      end
    end
  end

  // Ring buffer is never read before written within a block, so it has no reset.
  always_ff @(posedge CLK) begin
    if (in_fire)       ring[idx] <= D_IN;
    else if (exp_fire) ring[idx] <= w_new;
  end

endmodule
